adc_acq_top: RTL and testbench

Top-level acquisition controller for a serial-output ADC. While the start switch is on, it periodically issues a conversion-start pulse and generates the serial clock. It shifts in one DATA_W-bit sample MSB-first and presents the sample with busy/ready status. It sits directly between the FPGA board pins (clock, reset button, start switch) and the ADC serial interface.

---
 rtl/adc_acq_top.sv | 122 ++++++++++++
 tb/tb_adc_acq_top.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adc_acq_top.sv
// Acquisition controller for a serial-output ADC: periodic conversion start,
// serial clock generation and MSB-first sample capture with busy/ready status.
module adc_acq_top #(
    parameter int DATA_W        = 12,
    parameter int CLK_DIV       = 4,
    parameter int CONV_CYCLES   = 2,
    parameter int SAMPLE_PERIOD = 200
) (
    input  logic              fpga_clk,
    input  logic              button_rst,
    input  logic              start_switch,
    input  logic              S_DATA,
    output logic              S_CLK,
    output logic              CONV_ST,
    output logic              adc_busy,
    output logic              adc_ready,
    output logic [DATA_W-1:0] adc_data
);

    localparam int CNT_MAX = (CLK_DIV > CONV_CYCLES) ? CLK_DIV : CONV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int BIT_W   = $clog2(DATA_W) + 1;
    localparam int PER_W   = $clog2(SAMPLE_PERIOD) + 1;

    typedef enum logic [2:0] {IDLE, CONV, SHIFT, DONE, HOLD} state_t;

    state_t             state_q;
    logic               sync1_q, start_s_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIT_W-1:0]   bit_q;
    logic [PER_W-1:0]   per_q;
    logic [DATA_W-1:0]  shreg_q, shreg_d, data_q;
    logic               sclk_q, conv_q, busy_q, ready_q;

    assign shreg_d = {shreg_q[DATA_W-2:0], S_DATA};

    always_ff @(posedge fpga_clk) begin
        if (!button_rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            start_s_q <= 1'b0;
            cnt_q     <= '0;
            bit_q     <= '0;
            per_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            sclk_q    <= 1'b0;
            conv_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            sync1_q   <= start_switch;
            start_s_q <= sync1_q;
            ready_q   <= 1'b0;
            // Period counter tracks cycles since the last CONV_ST rising edge.
            if (state_q != IDLE) per_q <= per_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_s_q) begin
                        state_q <= CONV;
                        conv_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        per_q   <= '0;
                    end
                end
                CONV: begin
                    if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                        state_q <= SHIFT;
                        conv_q  <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        // Capture on the S_CLK high->low edge; data is stable by then.
                        if (sclk_q) begin
                            shreg_q <= shreg_d;
                            if (bit_q == BIT_W'(DATA_W - 1)) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                                data_q  <= shreg_d;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: state_q <= HOLD;
                HOLD: begin
                    if (per_q == PER_W'(SAMPLE_PERIOD - 1)) begin
                        per_q <= '0;
                        if (start_s_q) begin
                            state_q <= CONV;
                            conv_q  <= 1'b1;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign S_CLK     = sclk_q;
    assign CONV_ST   = conv_q;
    assign adc_busy  = busy_q;
    assign adc_ready = ready_q;
    assign adc_data  = data_q;

endmodule

// File: tb/tb_adc_acq_top.sv
// Bench for adc_acq_top: timeline model of the acquisition cycle, an ADC
// serial-data driver, and directed scenarios with literal expectations.
module tb_adc_acq_top;

    localparam int DW = 12;
    localparam int CD = 4;
    localparam int CC = 2;
    localparam int SP = 200;
    localparam int SH = 2 * CD * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sw = 1'b0;
    logic          sdata = 1'b0;
    logic          s_clk, conv_st, busy, ready;
    logic [DW-1:0] data;

    always #5 clk = ~clk;

    adc_acq_top #(.DATA_W(DW), .CLK_DIV(CD), .CONV_CYCLES(CC), .SAMPLE_PERIOD(SP)) dut (
        .fpga_clk(clk), .button_rst(rst_n), .start_switch(sw), .S_DATA(sdata),
        .S_CLK(s_clk), .CONV_ST(conv_st), .adc_busy(busy), .adc_ready(ready),
        .adc_data(data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: position t within the sample period decides every output.
    bit            m_active = 0;
    int            m_t = 0;
    bit            m_s1 = 0, m_s2 = 0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] cur_word = '0;
    int            cyc = 0;

    always @(posedge clk) begin
        bit s_old;
        cyc++;
        if (!rst_n) begin
            m_active = 0; m_t = 0; m_s1 = 0; m_s2 = 0; m_data = '0;
        end else begin
            s_old = m_s2;
            m_s2  = m_s1;
            m_s1  = sw;
            if (!m_active) begin
                if (s_old) begin m_active = 1; m_t = 0; end
            end else if (m_t == SP - 1) begin
                m_t = 0;
                if (!s_old) m_active = 0;
            end else begin
                m_t++;
            end
            if (m_active && m_t == CC + SH) m_data = cur_word;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("conv_st", conv_st, 32'(m_active && m_t < CC));
            chk("s_clk", s_clk, 32'(m_active && m_t >= CC && m_t < CC + SH && (((m_t - CC) / CD) % 2 == 1)));
            chk("busy", busy, 32'(m_active && m_t < CC + SH));
            chk("ready", ready, 32'(m_active && m_t == CC + SH));
            chk("data", data, 32'(m_data));
            chk("busy_ready_excl", busy & ready, 0);
            chk("conv_sclk_excl", conv_st & s_clk, 0);
        end
    end

    // ADC serial driver plus event monitor.
    bit            prev_conv = 0, prev_sclk = 0, pending = 0;
    int            rise_k = 0, conv_n = 0;
    int            n_rise = 0, n_ready = 0, last_rise = -1, run = 0;
    bit            chk_period = 0;
    logic [DW-1:0] first_data = '0;
    logic          first_busy = 1'b1;

    always @(negedge clk) begin
        if (conv_st && !prev_conv) begin
            cur_word = (conv_n == 0) ? 12'hA5C : DW'($urandom);
            conv_n++;
            rise_k = 0;
            pending = 0;
            n_rise++;
            if (chk_period && last_rise >= 0) chk("conv_period", cyc - last_rise, SP);
            last_rise = cyc;
        end
        if (conv_st) run++;
        else if (prev_conv) begin chk("conv_width", run, CC); run = 0; end
        if (pending) begin
            if (rise_k < DW) sdata = cur_word[DW-1-rise_k];
            rise_k++;
            pending = 0;
        end
        if (s_clk && !prev_sclk) pending = 1;
        if (ready) begin
            n_ready++;
            if (n_ready == 1) begin first_data = data; first_busy = busy; end
        end
        prev_conv = conv_st;
        prev_sclk = s_clk;
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    initial begin
        int r0, rc, k, w;
        rst_n = 1'b0;
        sw    = 1'b1;
        @(posedge clk);
        cmp_en = 1;
        step(10);
        chk("rst_data", data, 0);
        chk("rst_conv", conv_st, 0);
        chk("rst_sclk", s_clk, 0);

        rst_n = 1'b1;
        chk_period = 1;
        step(1000);
        chk("ready_count_1000", n_ready, 5);
        chk("rise_count_1000", n_rise, 5);
        chk("first_data", first_data, 12'hA5C);
        chk("first_busy", first_busy, 0);

        rc = n_rise;
        w = 0;
        while (n_rise == rc && w < 300) begin step(1); w++; end
        chk("stop_conv_seen", 32'(n_rise > rc), 1);
        step(44);
        sw = 1'b0;
        chk_period = 0;
        r0 = n_ready;
        step(150);
        chk("stop_ready_once", n_ready, r0 + 1);
        rc = n_rise;
        step(300);
        chk("no_conv_after_stop", n_rise, rc);
        chk("idle_busy", busy, 0);
        chk("stop_ready_total", n_ready, r0 + 1);

        sw = 1'b1;
        k = 0;
        while (!conv_st && k < 10) begin step(1); k++; end
        chk("restart_latency", 32'(k >= 3 && k <= 4), 1);

        step(30);
        r0 = n_ready;
        rst_n = 1'b0;
        step(1);
        chk("abort_sclk", s_clk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", data, 0);
        chk("abort_ready", ready, 0);
        sw = 1'b0;
        step(3);
        rst_n = 1'b1;
        rc = n_rise;
        step(250);
        chk("no_ready_after_abort", n_ready, r0);
        chk("no_conv_after_abort", n_rise, rc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
